// File: rtl/fibonacci_gen.sv
// fibonacci_gen: seeded Fibonacci-type term generator with term limit, overflow modes and valid/ready handshake
module fibonacci_gen #(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = 8,
    parameter int MAX_TERMS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [1:0]       mode,
    input  logic             f_en,
    input  logic             f_ready,
    output logic             f_valid,
    output logic [WIDTH-1:0] f_out,
    output logic [IDX_W-1:0] f_idx,
    output logic             f_ovf,
    output logic             f_done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [1:0] M_SAT  = 2'd1;
    localparam logic [1:0] M_STOP = 2'd2;
    localparam int         LAST   = (MAX_TERMS > 0) ? MAX_TERMS - 1 : 0;
    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_out, w_out, r_nxt, w_nxt;
    logic             r_nxt_c, w_nxt_c;
    logic [1:0]       r_mode, w_mode;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic             r_ovf, w_ovf;
    logic             w_xfer, w_last;
    logic [WIDTH:0]   w_sum;
    assign w_xfer  = (r_state == RUN) && f_ready && f_en;
    assign w_last  = (MAX_TERMS > 0) && (r_idx == IDX_W'(LAST));
    assign w_sum   = {1'b0, r_out} + {1'b0, r_nxt};
    assign f_valid = (r_state == RUN);
    assign f_done  = (r_state == DONE);
    assign f_out   = r_out;
    assign f_idx   = r_idx;
    assign f_ovf   = r_ovf;
    // State register; reset aborts any run and clears every output at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_nxt   <= '0;
            r_nxt_c <= 1'b0;
            r_mode  <= 2'd0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_out   <= w_out;
            r_nxt   <= w_nxt;
            r_nxt_c <= w_nxt_c;
            r_mode  <= w_mode;
            r_idx   <= w_idx;
            r_ovf   <= w_ovf;
        end
    end
    // Next state: start beats a transfer; limit beats overflow-stop; saturation pins nxt at all ones so it persists
    always_comb begin
        w_state = r_state;
        w_out   = r_out;
        w_nxt   = r_nxt;
        w_nxt_c = r_nxt_c;
        w_mode  = r_mode;
        w_idx   = r_idx;
        w_ovf   = r_ovf;
        if (start) begin
            w_state = RUN;
            w_out   = seed0;
            w_nxt   = seed1;
            w_nxt_c = 1'b0;
            w_mode  = mode;
            w_idx   = '0;
            w_ovf   = 1'b0;
        end else if (w_xfer) begin
            if (w_last || (r_nxt_c && r_mode == M_STOP)) begin
                w_state = DONE;
            end else if (r_nxt_c && r_mode == M_SAT) begin
                w_out   = '1;
                w_nxt   = '1;
                w_nxt_c = 1'b1;
                w_idx   = r_idx + 1'b1;
                w_ovf   = 1'b1;
            end else begin
                w_out   = r_nxt;
                w_nxt   = w_sum[WIDTH-1:0];
                w_nxt_c = w_sum[WIDTH];
                w_idx   = r_idx + 1'b1;
                w_ovf   = r_ovf | r_nxt_c;
            end
        end
    end
endmodule
